// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared types and helpers for the clock-divider controller.
//   state_e   : controller FSM states
//   DIV_MIN   : smallest divisor that still yields a high and a low phase
//   clamp_div : saturates a requested divisor up to DIV_MIN
package clock_div_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_e;

   localparam int unsigned DIV_MIN = 2;

   function automatic int unsigned clamp_div(input int unsigned d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/clock_div_counter.sv
// clock_div_counter: period counter plus divisor staging.
//   clk_i, rst_ni   : source clock, async active-low reset
//   run_i           : controller is in RUN or STOPPING
//   load_i          : a divisor transfer happens this cycle
//   load_bits_i     : raw requested divisor (clamped here)
//   cnt_o           : position inside the current period
//   cur_div_o       : divisor in effect
//   pend_valid_o    : a staged divisor waits for the next wrap
//   wrap_o          : last cycle of the current period
module clock_div_counter
   import clock_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_bits_i,
   output logic [DIV_W-1:0] cnt_o,
   output logic [DIV_W-1:0] cur_div_o,
   output logic             pend_valid_o,
   output logic             wrap_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_valid_q, pend_valid_d;
   logic [DIV_W-1:0] load_div;
   logic             wrap;

   assign load_div = DIV_W'(clamp_div(32'(load_bits_i)));
   assign wrap     = run_i && (cnt_q == (cur_div_q - DIV_W'(1)));

   // Counter sits at 0 while idle so a start always begins a full period.
   always_comb begin
      cnt_d = '0;
      if (run_i && !wrap) cnt_d = cnt_q + DIV_W'(1);
   end

   // A load can only happen while nothing is pending (ready = !pend_valid),
   // so it never collides with the wrap-time commit of a staged divisor.
   always_comb begin
      cur_div_d    = cur_div_q;
      pend_div_d   = pend_div_q;
      pend_valid_d = pend_valid_q;
      if (wrap && pend_valid_q) begin
         cur_div_d    = pend_div_q;
         pend_valid_d = 1'b0;
      end
      if (load_i) begin
         if (!run_i) begin
            // No waveform in flight: take effect immediately.
            cur_div_d = load_div;
         end else begin
            pend_div_d   = load_div;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         cur_div_q    <= DIV_W'(DEFAULT_DIV);
         pend_div_q   <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         cur_div_q    <= cur_div_d;
         pend_div_q   <= pend_div_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   assign cnt_o        = cnt_q;
   assign cur_div_o    = cur_div_q;
   assign pend_valid_o = pend_valid_q;
   assign wrap_o       = wrap;

endmodule

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock-divider controller.
//   clock, reset   : source clock, async active-low reset
//   enable         : run request for the divided clock
//   div_req_*      : valid/ready divisor request (0 and 1 clamp to 2)
//   flop_d         : waveform for the clock flop d input (high floor(D/2))
//   gate_en        : enable for the downstream clock gater
//   current_div    : divisor in effect
//   busy           : a divisor change is waiting for a period boundary
// All outputs decode from registered state only.
module clock_div_ctrl
   import clock_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_req_valid,
   output logic             div_req_ready,
   input  logic [DIV_W-1:0] div_req_bits,
   output logic             flop_d,
   output logic             gate_en,
   output logic [DIV_W-1:0] current_div,
   output logic             busy
);

   state_e           state_q, state_d;
   logic             running;
   logic             accept;
   logic             wrap;
   logic             pend_valid;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cur_div;

   assign running = (state_q != IDLE);
   assign accept  = div_req_valid && !pend_valid;

   clock_div_counter #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_counter (
      .clk_i        (clock),
      .rst_ni       (reset),
      .run_i        (running),
      .load_i       (accept),
      .load_bits_i  (div_req_bits),
      .cnt_o        (cnt),
      .cur_div_o    (cur_div),
      .pend_valid_o (pend_valid),
      .wrap_o       (wrap)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (enable) state_d = RUN;
         // A drop of enable on the wrap cycle lets the new period start in
         // RUN; STOPPING is entered on the following cycle.
         RUN:      if (!enable && !wrap) state_d = STOPPING;
         // Wrap wins over a re-raised enable: the period ends and we idle.
         STOPPING: begin
            if (wrap)        state_d = IDLE;
            else if (enable) state_d = RUN;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      gate_en = running;
      flop_d  = running && (cnt < (cur_div >> 1));
   end

   assign div_req_ready = !pend_valid;
   assign busy          = pend_valid;
   assign current_div   = cur_div;

endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;

   localparam int DIV_W = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic             div_req_valid = 1'b0;
   logic [DIV_W-1:0] div_req_bits = '0;
   logic             div_req_ready;
   logic             flop_d;
   logic             gate_en;
   logic [DIV_W-1:0] current_div;
   logic             busy;

   int checks = 0;
   int errors = 0;

   clock_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(2)) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .div_req_valid (div_req_valid),
      .div_req_ready (div_req_ready),
      .div_req_bits  (div_req_bits),
      .flop_d        (flop_d),
      .gate_en       (gate_en),
      .current_div   (current_div),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   // Behavioural reference: the divider is "on" or "off"; when on it walks
   // a position through a period of m_div cycles. A stop request lets the
   // current period finish.
   int m_on, m_pos, m_div, m_pend, m_pv, m_stop;

   task automatic model_reset();
      m_on = 0; m_pos = 0; m_div = 2; m_pend = 0; m_pv = 0; m_stop = 0;
   endtask

   task automatic model_step(input int en, input int v, input int bits);
      int acc, cl, last;
      acc  = (v != 0) && (m_pv == 0);
      cl   = (bits < 2) ? 2 : bits;
      if (m_on == 0) begin
         if (acc) m_div = cl;
         if (en != 0) begin m_on = 1; m_pos = 0; m_stop = 0; end
      end else begin
         last = (m_pos == m_div - 1);
         if (last && m_pv != 0) begin m_div = m_pend; m_pv = 0; end
         if (acc) begin m_pend = cl; m_pv = 1; end
         if (last) begin
            m_pos = 0;
            if (m_stop != 0) m_on = 0;
            m_stop = 0;
         end else begin
            m_pos++;
            m_stop = (en == 0);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      enable = 1'b0; div_req_valid = 1'b0; div_req_bits = '0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic program_idle(input int d);
      div_req_valid = 1'b1; div_req_bits = DIV_W'(d);
      tick();
      div_req_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (flop_d !== 1'b0) begin errors++; $display("FAIL reset flop_d got %0b exp 0", flop_d); end
      checks++; if (gate_en !== 1'b0) begin errors++; $display("FAIL reset gate_en got %0b exp 0", gate_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %0b exp 0", busy); end
      checks++; if (div_req_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %0b exp 1", div_req_ready); end
      checks++; if (current_div !== 8'd2) begin errors++; $display("FAIL reset current_div got %0d exp 2", current_div); end
   endtask

   task automatic test_waveform(input int d);
      logic e;
      do_reset();
      program_idle(d);
      checks++; if (current_div !== DIV_W'(d)) begin errors++; $display("FAIL wave%0d current_div got %0d exp %0d", d, current_div, d); end
      checks++; if (gate_en !== 1'b0) begin errors++; $display("FAIL wave%0d idle gate_en got %0b exp 0", d, gate_en); end
      enable = 1'b1;
      tick();
      for (int k = 0; k < 3 * d; k++) begin
         e = ((k % d) < (d / 2));
         checks++; if (flop_d !== e) begin errors++; $display("FAIL wave%0d flop_d k=%0d got %0b exp %0b", d, k, flop_d, e); end
         checks++; if (gate_en !== 1'b1) begin errors++; $display("FAIL wave%0d gate_en k=%0d got %0b exp 1", d, k, gate_en); end
         tick();
      end
   endtask

   task automatic test_change();
      logic e;
      do_reset();
      program_idle(4);
      enable = 1'b1;
      tick();  // cnt 0
      tick();  // cnt 1
      checks++; if (div_req_ready !== 1'b1) begin errors++; $display("FAIL change ready_pre got %0b exp 1", div_req_ready); end
      div_req_valid = 1'b1; div_req_bits = 8'd6;
      tick();  // cnt 2
      div_req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if (busy !== 1'b1 || div_req_ready !== 1'b0) begin errors++; $display("FAIL change busy k=%0d got %0b/%0b exp 1/0", k, busy, div_req_ready); end
         checks++; if (flop_d !== 1'b0) begin errors++; $display("FAIL change tail k=%0d got %0b exp 0", k, flop_d); end
         checks++; if (current_div !== 8'd4) begin errors++; $display("FAIL change old_div got %0d exp 4", current_div); end
         tick();
      end
      checks++; if (busy !== 1'b0 || current_div !== 8'd6) begin errors++; $display("FAIL change commit got busy %0b div %0d exp 0 6", busy, current_div); end
      for (int k = 0; k < 12; k++) begin
         e = ((k % 6) < 3);
         checks++; if (flop_d !== e) begin errors++; $display("FAIL change d6 k=%0d got %0b exp %0b", k, flop_d, e); end
         tick();
      end
   endtask

   task automatic test_clamp_holdoff();
      int n;
      do_reset();
      program_idle(5);
      program_idle(1);
      checks++; if (current_div !== 8'd2 || busy !== 1'b0) begin errors++; $display("FAIL clamp got div %0d busy %0b exp 2 0", current_div, busy); end
      enable = 1'b1;
      tick();
      div_req_valid = 1'b1; div_req_bits = 8'd0;
      tick();
      div_req_bits = 8'd7;  // held high while busy: must not transfer
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL holdoff busy got %0b exp 1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 10) begin tick(); n++; end
      div_req_valid = 1'b0;
      checks++; if (n >= 10) begin errors++; $display("FAIL holdoff timeout got %0d cycles exp <10", n); end
      checks++; if (current_div !== 8'd2) begin errors++; $display("FAIL holdoff div got %0d exp 2", current_div); end
      tick();
      checks++; if (busy !== 1'b0 || current_div !== 8'd2) begin errors++; $display("FAIL holdoff extra got busy %0b div %0d exp 0 2", busy, current_div); end
   endtask

   task automatic test_stop_restart();
      logic [3:0] ef;
      logic [3:0] eg;
      logic [7:0] rf;
      do_reset();
      program_idle(4);
      enable = 1'b1;
      tick();          // cnt 0
      enable = 1'b0;
      ef = 4'b1100; eg = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         checks++; if (flop_d !== ef[3-k] || gate_en !== eg[3-k]) begin errors++; $display("FAIL stop k=%0d got %0b/%0b exp %0b/%0b", k, flop_d, gate_en, ef[3-k], eg[3-k]); end
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         checks++; if (flop_d !== 1'b0 || gate_en !== 1'b0) begin errors++; $display("FAIL stop idle k=%0d got %0b/%0b exp 0/0", k, flop_d, gate_en); end
         tick();
      end
      enable = 1'b1;
      tick();          // cnt 0
      tick();          // cnt 1
      enable = 1'b0;
      tick();          // cnt 2, stopping
      enable = 1'b1;
      rf = 8'b00110011;
      for (int k = 0; k < 8; k++) begin
         checks++; if (flop_d !== rf[7-k] || gate_en !== 1'b1) begin errors++; $display("FAIL restart k=%0d got %0b/%0b exp %0b/1", k, flop_d, gate_en, rf[7-k]); end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      program_idle(6);
      program_idle(9);  // idle writes are direct, so this overrides
      program_idle(6);
      enable = 1'b1;
      tick();
      tick();          // cnt 1
      checks++; if (flop_d !== 1'b1 || gate_en !== 1'b1) begin errors++; $display("FAIL areset pre got %0b/%0b exp 1/1", flop_d, gate_en); end
      #2 reset = 1'b0;
      #1;
      checks++; if (flop_d !== 1'b0 || gate_en !== 1'b0) begin errors++; $display("FAIL areset async got %0b/%0b exp 0/0", flop_d, gate_en); end
      @(negedge clock);
      enable = 1'b0;
      reset = 1'b1;
      checks++; if (current_div !== 8'd2 || busy !== 1'b0 || div_req_ready !== 1'b1) begin errors++; $display("FAIL areset post got div %0d busy %0b rdy %0b exp 2 0 1", current_div, busy, div_req_ready); end
   endtask

   task automatic test_random();
      logic ef;
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         ef = (m_on != 0) && (m_pos < m_div / 2);
         checks++; if (flop_d !== ef) begin errors++; $display("FAIL rand flop_d c=%0d got %0b exp %0b", c, flop_d, ef); end
         checks++; if (gate_en !== (m_on != 0)) begin errors++; $display("FAIL rand gate_en c=%0d got %0b exp %0d", c, gate_en, m_on); end
         checks++; if (current_div !== DIV_W'(m_div)) begin errors++; $display("FAIL rand div c=%0d got %0d exp %0d", c, current_div, m_div); end
         checks++; if (busy !== (m_pv != 0) || div_req_ready !== (m_pv == 0)) begin errors++; $display("FAIL rand busy c=%0d got %0b/%0b exp pend %0d", c, busy, div_req_ready, m_pv); end
         if ($urandom_range(0, 11) == 0) enable = ~enable;
         div_req_valid = ($urandom_range(0, 3) == 0);
         div_req_bits  = DIV_W'($urandom_range(0, 12));
         @(posedge clock);
         model_step(int'(enable), int'(div_req_valid), int'(div_req_bits));
         @(negedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_waveform(4);
      test_waveform(5);
      test_waveform(2);
      test_change();
      test_clamp_holdoff();
      test_stop_restart();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
